// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the boot-time instruction-memory loader.
package loader_pkg;
  localparam int unsigned COUNT_WIDTH = 16;
  localparam int unsigned BYTE_WIDTH  = 8;
  localparam int unsigned CSUM_WIDTH  = 8;
  localparam int unsigned WORD_WIDTH  = 32;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    CSUM,
    RUN,
    ERR
  } state_e;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write / core-release outputs of the loader.
interface imem_loader_if
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned SIZE       = 32
);
  logic                  in_valid;
  logic [BYTE_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_waddr;
  logic [SIZE-1:0]       imem_wdata;
  logic                  core_rst_n;
  logic                  done;
  logic                  err;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_waddr, imem_wdata, core_rst_n, done, err
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_waddr, imem_wdata, core_rst_n, done, err
  );
endinterface

// File: rtl/imem_loader_word_packer.sv
// Packs little-endian bytes into 32-bit words and keeps a running XOR of every data byte.
module word_packer
  import loader_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  byte_en_i,
  input  logic [BYTE_WIDTH-1:0] byte_i,
  output logic                  word_ready_o,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic [CSUM_WIDTH-1:0] csum_o
);
  logic [1:0]                       cnt_q;
  logic [WORD_WIDTH-BYTE_WIDTH-1:0] shift_q;
  logic [CSUM_WIDTH-1:0]            csum_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      shift_q <= '0;
      csum_q  <= '0;
    end else if (clr_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
      csum_q  <= '0;
    end else if (byte_en_i) begin
      cnt_q   <= cnt_q + 2'd1;
      shift_q <= {byte_i, shift_q[WORD_WIDTH-BYTE_WIDTH-1:BYTE_WIDTH]};
      csum_q  <= csum_q ^ byte_i;
    end
  end

  // The 4th byte completes the word combinationally so the top can register it on the same edge.
  assign word_ready_o = byte_en_i && (cnt_q == 2'd3);
  assign word_o       = {byte_i, shift_q};
  assign csum_o       = csum_q;
endmodule

// File: rtl/imem_loader.sv
// Frame parser: header count, sequential word writes into instruction RAM, checksum gate on core reset.
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned SIZE       = 32
)(
  input  logic        CLK,
  input  logic        RESET_N,
  imem_loader_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  state_e                 state_q;
  logic [ADDR_WIDTH:0]    idx_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [BYTE_WIDTH-1:0]  count_lo_q;
  logic                   in_ready_q;
  logic                   imem_we_q;
  logic [ADDR_WIDTH-1:0]  imem_waddr_q;
  logic [SIZE-1:0]        imem_wdata_q;
  logic                   core_rst_n_q;
  logic                   done_q;
  logic                   err_q;

  logic                   accept;
  logic [COUNT_WIDTH-1:0] hdr_count;
  logic                   hdr_bad;
  logic                   last_word;
  logic                   word_ready;
  logic [WORD_WIDTH-1:0]  word;
  logic [CSUM_WIDTH-1:0]  csum;

  assign accept    = bus.in_valid && in_ready_q;
  assign hdr_count = {bus.in_data, count_lo_q};
  assign hdr_bad   = (hdr_count == '0) || (32'(hdr_count) > DEPTH);
  // Index is one bit wider than the address so a full-depth frame ends without wrapping.
  assign last_word = (32'(idx_q) + 32'd1) == 32'(count_q);

  word_packer u_packer (
    .clk_i        (CLK),
    .rst_ni       (RESET_N),
    .clr_i        (accept && (state_q == HDR1)),
    .byte_en_i    (accept && (state_q == DATA)),
    .byte_i       (bus.in_data),
    .word_ready_o (word_ready),
    .word_o       (word),
    .csum_o       (csum)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= HDR0;
      idx_q        <= '0;
      count_q      <= '0;
      count_lo_q   <= '0;
      in_ready_q   <= 1'b1;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= '0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        HDR0: begin
          if (accept) begin
            count_lo_q <= bus.in_data;
            state_q    <= HDR1;
          end
        end
        HDR1: begin
          if (accept) begin
            count_q <= hdr_count;
            idx_q   <= '0;
            if (hdr_bad) begin
              state_q    <= ERR;
              in_ready_q <= 1'b0;
              err_q      <= 1'b1;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (word_ready) begin
            imem_we_q    <= 1'b1;
            imem_waddr_q <= idx_q[ADDR_WIDTH-1:0];
            imem_wdata_q <= word;
            idx_q        <= idx_q + 1'b1;
            if (last_word) state_q <= CSUM;
          end
        end
        CSUM: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            if (bus.in_data == csum) begin
              state_q      <= RUN;
              done_q       <= 1'b1;
              core_rst_n_q <= 1'b1;
            end else begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end
          end
        end
        RUN, ERR: ;
        default: begin
          state_q    <= ERR;
          in_ready_q <= 1'b0;
          err_q      <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_waddr = imem_waddr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.core_rst_n = core_rst_n_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued at stimulus time, checked by a write monitor.
module tb_imem_loader;
  localparam int unsigned AW = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_WIDTH(AW), .SIZE(32)) bus ();

  imem_loader #(.ADDR_WIDTH(AW), .SIZE(32)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           mon_e;
  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_writes = 0;
  logic [AW-1:0] last_waddr = '0;

  logic [7:0] GOOD [11] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                            8'h13, 8'h01, 8'h10, 8'h00, 8'hC1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.imem_we === 1'b1) begin
      n_writes++;
      last_waddr = bus.imem_waddr;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(bus.imem_waddr), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("waddr", 32'(bus.imem_waddr), 32'(mon_e.addr));
        check("wdata", bus.imem_wdata, mon_e.data);
      end
    end
  end

  function automatic int unsigned gap_for(input int mode);
    case (mode)
      1:       return 1;
      2:       return $urandom_range(0, 2);
      default: return 0;
    endcase
  endfunction

  task automatic send(input logic [7:0] b, input int unsigned gap);
    int unsigned waited;
    waited = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
    end
  endtask

  task automatic push_good();
    exp_q.push_back('{addr: 10'd0, data: 32'h0050_0093});
    exp_q.push_back('{addr: 10'd1, data: 32'h0010_0113});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},   32'(bus.in_ready),   32'd1);
    check({tag, "_imem_we"},    32'(bus.imem_we),    32'd0);
    check({tag, "_waddr"},      32'(bus.imem_waddr), 32'd0);
    check({tag, "_wdata"},      bus.imem_wdata,      32'd0);
    check({tag, "_core_rst_n"}, 32'(bus.core_rst_n), 32'd0);
    check({tag, "_done"},       32'(bus.done),       32'd0);
    check({tag, "_err"},        32'(bus.err),        32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_vals(tag);
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic check_final(input string tag, input logic done_e, input logic err_e);
    @(negedge clk);
    check({tag, "_done"},       32'(bus.done),       32'(done_e));
    check({tag, "_err"},        32'(bus.err),        32'(err_e));
    check({tag, "_core_rst_n"}, 32'(bus.core_rst_n), 32'(done_e));
    check({tag, "_in_ready"},   32'(bus.in_ready),   32'd0);
    check({tag, "_pending"},    32'(exp_q.size()),   32'd0);
  endtask

  task automatic good_frame(input string tag, input int mode);
    push_good();
    foreach (GOOD[i]) send(GOOD[i], gap_for(mode));
    check_final(tag, 1'b1, 1'b0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    good_frame("good", 0);
    // Bytes offered after completion must be left unconsumed.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    repeat (3) @(negedge clk);
    check("run_ignore_ready", 32'(bus.in_ready), 32'd0);
    check("run_ignore_done",  32'(bus.done),     32'd1);
    bus.in_valid = 1'b0;

    do_reset("rst1");
    push_good();
    for (int i = 0; i < 10; i++) send(GOOD[i], 0);
    send(8'hC0, 0);
    check_final("badcsum", 1'b0, 1'b1);

    do_reset("rst2");
    n_writes = 0;
    send(8'h00, 0);
    send(8'h00, 0);
    check_final("zero_n", 1'b0, 1'b1);

    do_reset("rst3");
    send(8'h01, 0);
    send(8'h04, 0);
    check_final("n1025", 1'b0, 1'b1);
    check("hdr_err_no_writes", 32'(n_writes), 32'd0);

    do_reset("rst4");
    good_frame("toggle", 1);
    do_reset("rst5");
    good_frame("stall", 2);

    do_reset("rst6");
    begin
      logic [7:0]  csum;
      logic [31:0] w;
      csum = '0;
      n_writes = 0;
      send(8'h00, 0);
      send(8'h04, 0);
      for (int i = 0; i < 1024; i++) begin
        w = {8'hA5 ^ 8'(i), 8'h3C, 8'(i >> 8), 8'(i)};
        exp_q.push_back('{addr: 10'(i), data: w});
        for (int k = 0; k < 4; k++) begin
          csum = csum ^ w[8*k +: 8];
          send(w[8*k +: 8], 0);
        end
      end
      send(csum, 0);
      check_final("full", 1'b1, 1'b0);
      check("full_last_addr", 32'(last_waddr), 32'd1023);
      check("full_write_count", 32'(n_writes), 32'd1024);
    end

    do_reset("rst7");
    exp_q.push_back('{addr: 10'd0, data: 32'h0050_0093});
    for (int i = 0; i < 8; i++) send(GOOD[i], 0);
    @(negedge clk);
    check("midframe_pending", 32'(exp_q.size()), 32'd0);
    do_reset("midrst");
    good_frame("after_rst", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
